kbd_repeat_sched: RTL and testbench

//  Sits between the PS/2 keyboard front end (cur_key/ascii_key/modifier outputs) and the consumer
//  (terminal/CPU I/O port). Detects key-down edges, schedules typematic auto-repeat (delay then rate)
//  and queues press/repeat events into a show-ahead FIFO with a valid/read handshake and sticky overflow.

---
 rtl/kbd_repeat_sched_pkg.sv | 36 +++
 rtl/kbd_repeat_sched_if.sv | 31 +++
 rtl/kbd_repeat_sched_evt_fifo.sv | 73 +++++++
 rtl/kbd_repeat_sched.sv | 146 ++++++++++++++
 tb/tb_kbd_repeat_sched.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/kbd_repeat_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : kbd_repeat_sched_pkg
//  Purpose  : Shared types and constants for the keyboard typematic
//             scheduler: event word layout, FSM state encoding and the
//             "no key" scan code shared with the PS/2 front end.
//  Ports    : (package - none)
//  Revision : 1.0  initial release
// ============================================================================
package kbd_repeat_sched_pkg;

    // Event word: [19] rep, [18:16] mods {ctrl,alt,shift}, [15:8] scan, [7:0] ascii
    localparam int EV_W = 20;

    typedef struct packed {
        logic       rep;
        logic [2:0] mods;
        logic [7:0] scan;
        logic [7:0] ascii;
    } ev_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    // Front end reports 0 when no key is held
    localparam logic [7:0] SC_NONE = 8'h00;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : kbd_repeat_sched_pkg
`default_nettype wire

// File: rtl/kbd_repeat_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : kbd_repeat_sched_if
//  Purpose  : Event-queue handshake between the scheduler and its consumer.
//  Signals  : ev_valid/ev_scan/ev_ascii/ev_mods/ev_rep - head event (producer)
//             ovf                                      - sticky drop flag (producer)
//             ev_rd, ovf_clr                           - pop / clear (consumer)
//  Modports : master = scheduler side, slave = consumer side
//  Revision : 1.0  initial release
// ============================================================================
interface kbd_repeat_sched_if;
    logic       ev_valid;
    logic [7:0] ev_scan;
    logic [7:0] ev_ascii;
    logic [2:0] ev_mods;
    logic       ev_rep;
    logic       ev_rd;
    logic       ovf;
    logic       ovf_clr;

    modport master (
        output ev_valid, ev_scan, ev_ascii, ev_mods, ev_rep, ovf,
        input  ev_rd, ovf_clr
    );

    modport slave (
        input  ev_valid, ev_scan, ev_ascii, ev_mods, ev_rep, ovf,
        output ev_rd, ovf_clr
    );
endinterface : kbd_repeat_sched_if
`default_nettype wire

// File: rtl/kbd_repeat_sched_evt_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : kbd_evt_fifo
//  Purpose  : Show-ahead synchronous FIFO for keyboard events. A pop frees a
//             slot in the same cycle, so push+pop while full both succeed.
//  Ports    : clk, clrn (async active-low)
//             push, din    - write request / data
//             pop          - read request (ignored when empty)
//             dout         - head entry (valid when !empty)
//             empty        - queue empty
//             dropped      - push rejected this cycle (full, no pop)
//  Revision : 1.0  initial release
// ============================================================================
module kbd_evt_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 16
) (
    input  wire logic             clk,
    input  wire logic             clrn,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] din,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  dropped
);

    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign empty     = (r_count == '0);
    assign w_full    = (r_count == (c_aw+1)'(DEPTH));
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!w_full || w_do_pop);
    assign dropped   = push && w_full && !w_do_pop;
    assign dout      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : kbd_evt_fifo
`default_nettype wire

// File: rtl/kbd_repeat_sched.sv
`default_nettype none
// ============================================================================
//  Module   : kbd_repeat_sched
//  Purpose  : Key-down edge detection and typematic auto-repeat scheduling.
//             Press and repeat events are queued in a show-ahead FIFO with
//             a sticky overflow flag.
//  Ports    : clk, clrn            - clock, async active-low reset
//             cur_key, ascii_key   - held scan code (0 = none) and its ASCII
//             shift, ctrl, alt     - modifier levels, captured at push
//             rep_en               - auto-repeat enable
//             ev (master modport)  - event queue head, pop, overflow
//  Revision : 1.0  initial release
// ============================================================================
module kbd_repeat_sched
    import kbd_repeat_sched_pkg::*;
#(
    parameter int DELAY_CYC  = 25_000_000,
    parameter int RATE_CYC   = 2_500_000,
    parameter int FIFO_DEPTH = 16
) (
    input  wire logic             clk,
    input  wire logic             clrn,
    input  wire logic [7:0]       cur_key,
    input  wire logic [7:0]       ascii_key,
    input  wire logic             shift,
    input  wire logic             ctrl,
    input  wire logic             alt,
    input  wire logic             rep_en,
    kbd_repeat_sched_if.master    ev
);

    localparam int c_cnt_w = max_int(1, $clog2(max_int(DELAY_CYC, RATE_CYC)));
    localparam logic [c_cnt_w-1:0] c_delay_last = c_cnt_w'(DELAY_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_rate_last  = c_cnt_w'(RATE_CYC - 1);

    logic [7:0]         r_key_q;
    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_ovf;

    logic       w_press;
    logic       w_release;
    logic       w_delay_done;
    logic       w_rate_done;
    logic       w_timer_push;
    logic       w_push;
    ev_t        w_push_ev;
    ev_t        w_head;
    logic       w_empty;
    logic       w_dropped;
    logic [EV_W-1:0] w_fifo_dout;

    // Any change to a new nonzero code is a press, including rollover
    assign w_press      = (cur_key != SC_NONE) && (cur_key != r_key_q);
    assign w_release    = (cur_key == SC_NONE);
    assign w_delay_done = rep_en && (r_cnt == c_delay_last);
    assign w_rate_done  = rep_en && (r_cnt == c_rate_last);

    // Timer expiry only counts when no press/release claims the cycle
    assign w_timer_push = !w_press && !w_release &&
                          (((r_state == ST_DELAY)  && w_delay_done) ||
                           ((r_state == ST_REPEAT) && w_rate_done));
    assign w_push       = w_press || w_timer_push;

    always_comb begin
        w_push_ev       = '0;
        w_push_ev.rep   = !w_press;
        w_push_ev.mods  = {ctrl, alt, shift};
        w_push_ev.scan  = cur_key;
        w_push_ev.ascii = ascii_key;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_key_q <= '0;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_key_q <= cur_key;

            if (w_dropped) begin
                r_ovf <= 1'b1;
            end else if (ev.ovf_clr) begin
                r_ovf <= 1'b0;
            end

            if (w_press) begin
                r_state <= ST_DELAY;
                r_cnt   <= '0;
            end else if (w_release) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    ST_DELAY: begin
                        if (!rep_en) begin
                            r_cnt <= '0;
                        end else if (w_delay_done) begin
                            r_state <= ST_REPEAT;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (!rep_en || w_rate_done) begin
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    kbd_evt_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .clrn    (clrn),
        .push    (w_push),
        .din     (w_push_ev),
        .pop     (ev.ev_rd),
        .dout    (w_fifo_dout),
        .empty   (w_empty),
        .dropped (w_dropped)
    );

    // Fields read as zero whenever the queue is empty
    assign w_head      = w_empty ? '0 : ev_t'(w_fifo_dout);
    assign ev.ev_valid = !w_empty;
    assign ev.ev_scan  = w_head.scan;
    assign ev.ev_ascii = w_head.ascii;
    assign ev.ev_mods  = w_head.mods;
    assign ev.ev_rep   = w_head.rep;
    assign ev.ovf      = r_ovf;

endmodule : kbd_repeat_sched
`default_nettype wire

// File: tb/tb_kbd_repeat_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kbd_repeat_sched
//  Purpose  : Directed bench for kbd_repeat_sched with DELAY_CYC=20,
//             RATE_CYC=5, FIFO_DEPTH=4. Each table row holds inputs for a
//             number of clocks, then the expected queue head and ovf.
//  Revision : 1.0  initial release
// ============================================================================
module tb_kbd_repeat_sched;

    logic       clk = 1'b0;
    logic       clrn;
    logic [7:0] cur_key;
    logic [7:0] ascii_key;
    logic       shift, ctrl, alt;
    logic       rep_en;

    int pass_cnt  = 0;
    int total_cnt = 0;

    kbd_repeat_sched_if ev_if ();

    kbd_repeat_sched #(
        .DELAY_CYC  (20),
        .RATE_CYC   (5),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .cur_key   (cur_key),
        .ascii_key (ascii_key),
        .shift     (shift),
        .ctrl      (ctrl),
        .alt       (alt),
        .rep_en    (rep_en),
        .ev        (ev_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] key;
        logic [7:0] asc;
        logic [2:0] mods;   // {ctrl,alt,shift}
        logic       ren;
        logic       rd;
        logic       clr;
        int         cyc;
        logic       e_valid;
        logic [7:0] e_scan;
        logic [7:0] e_asc;
        logic [2:0] e_mods;
        logic       e_rep;
        logic       e_ovf;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic [7:0] key, input logic [7:0] asc,
                                input logic [2:0] mods, input logic ren,
                                input logic rd, input logic clr, input int cyc,
                                input logic e_valid, input logic [7:0] e_scan,
                                input logic [7:0] e_asc, input logic [2:0] e_mods,
                                input logic e_rep, input logic e_ovf);
        vec_t v;
        v.key = key; v.asc = asc; v.mods = mods; v.ren = ren; v.rd = rd;
        v.clr = clr; v.cyc = cyc; v.e_valid = e_valid; v.e_scan = e_scan;
        v.e_asc = e_asc; v.e_mods = e_mods; v.e_rep = e_rep; v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Idle stream, pop on; drains anything left over
        vecs.push_back(mk(8'h00,8'h00,3'd0,1,1,0, 3, 0,8'h00,8'h00,3'd0,0,0));
        // Repeat timing: press, repeats at +20, +25, +30 (shift captured at +25)
        vecs.push_back(mk(8'h1C,8'h61,3'd0,1,1,0, 1, 1,8'h1C,8'h61,3'd0,0,0));
        vecs.push_back(mk(8'h1C,8'h61,3'd0,1,1,0, 1, 0,8'h00,8'h00,3'd0,0,0));
        vecs.push_back(mk(8'h1C,8'h61,3'd0,1,1,0,18, 0,8'h00,8'h00,3'd0,0,0));
        vecs.push_back(mk(8'h1C,8'h61,3'd0,1,1,0, 1, 1,8'h1C,8'h61,3'd0,1,0));
        vecs.push_back(mk(8'h1C,8'h61,3'd0,1,1,0, 1, 0,8'h00,8'h00,3'd0,0,0));
        vecs.push_back(mk(8'h1C,8'h61,3'd1,1,1,0, 3, 0,8'h00,8'h00,3'd0,0,0));
        vecs.push_back(mk(8'h1C,8'h61,3'd1,1,1,0, 1, 1,8'h1C,8'h61,3'd1,1,0));
        vecs.push_back(mk(8'h1C,8'h61,3'd0,1,1,0, 4, 0,8'h00,8'h00,3'd0,0,0));
        vecs.push_back(mk(8'h1C,8'h61,3'd0,1,1,0, 1, 1,8'h1C,8'h61,3'd0,1,0));
        vecs.push_back(mk(8'h00,8'h00,3'd0,1,1,0, 1, 0,8'h00,8'h00,3'd0,0,0));
        vecs.push_back(mk(8'h00,8'h00,3'd0,1,1,0,30, 0,8'h00,8'h00,3'd0,0,0));
        // Rollover: 1C for 12 cycles then 32; no 1C repeat, 32 repeats at +20
        vecs.push_back(mk(8'h1C,8'h61,3'd0,1,1,0, 1, 1,8'h1C,8'h61,3'd0,0,0));
        vecs.push_back(mk(8'h1C,8'h61,3'd0,1,1,0,11, 0,8'h00,8'h00,3'd0,0,0));
        vecs.push_back(mk(8'h32,8'h62,3'd0,1,1,0, 1, 1,8'h32,8'h62,3'd0,0,0));
        vecs.push_back(mk(8'h32,8'h62,3'd0,1,1,0, 8, 0,8'h00,8'h00,3'd0,0,0));
        vecs.push_back(mk(8'h32,8'h62,3'd0,1,1,0,11, 0,8'h00,8'h00,3'd0,0,0));
        vecs.push_back(mk(8'h32,8'h62,3'd0,1,1,0, 1, 1,8'h32,8'h62,3'd0,1,0));
        // Release at press+22: exactly one press and one repeat queued
        vecs.push_back(mk(8'h00,8'h00,3'd0,1,1,0, 2, 0,8'h00,8'h00,3'd0,0,0));
        vecs.push_back(mk(8'h1C,8'h61,3'd0,1,0,0, 1, 1,8'h1C,8'h61,3'd0,0,0));
        vecs.push_back(mk(8'h1C,8'h61,3'd0,1,0,0,21, 1,8'h1C,8'h61,3'd0,0,0));
        vecs.push_back(mk(8'h00,8'h00,3'd0,1,1,0, 1, 1,8'h1C,8'h61,3'd0,1,0));
        vecs.push_back(mk(8'h00,8'h00,3'd0,1,1,0, 1, 0,8'h00,8'h00,3'd0,0,0));
        vecs.push_back(mk(8'h00,8'h00,3'd0,1,1,0,30, 0,8'h00,8'h00,3'd0,0,0));
        // Overflow: never pop for 40 cycles; clear loses to a drop at +40
        vecs.push_back(mk(8'h1C,8'h61,3'd0,1,0,0, 1, 1,8'h1C,8'h61,3'd0,0,0));
        vecs.push_back(mk(8'h1C,8'h61,3'd0,1,0,0,39, 1,8'h1C,8'h61,3'd0,0,1));
        vecs.push_back(mk(8'h1C,8'h61,3'd0,1,0,1, 1, 1,8'h1C,8'h61,3'd0,0,1));
        vecs.push_back(mk(8'h1C,8'h61,3'd0,1,0,1, 1, 1,8'h1C,8'h61,3'd0,0,0));
        vecs.push_back(mk(8'h1C,8'h61,3'd0,1,0,0, 3, 1,8'h1C,8'h61,3'd0,0,0));
        // Push + pop while full at +45: head advances, no drop, still 4 entries
        vecs.push_back(mk(8'h1C,8'h61,3'd0,1,1,0, 1, 1,8'h1C,8'h61,3'd0,1,0));
        vecs.push_back(mk(8'h00,8'h00,3'd0,1,1,0, 3, 1,8'h1C,8'h61,3'd0,1,0));
        vecs.push_back(mk(8'h00,8'h00,3'd0,1,1,0, 1, 0,8'h00,8'h00,3'd0,0,0));
        // rep_en low for 50 cycles: press only; enable -> repeat 20 cycles later
        vecs.push_back(mk(8'h00,8'h00,3'd0,1,1,0, 2, 0,8'h00,8'h00,3'd0,0,0));
        vecs.push_back(mk(8'h1C,8'h61,3'd0,0,1,0, 1, 1,8'h1C,8'h61,3'd0,0,0));
        vecs.push_back(mk(8'h1C,8'h61,3'd0,0,1,0,50, 0,8'h00,8'h00,3'd0,0,0));
        vecs.push_back(mk(8'h1C,8'h61,3'd0,1,1,0,19, 0,8'h00,8'h00,3'd0,0,0));
        vecs.push_back(mk(8'h1C,8'h61,3'd0,1,1,0, 1, 1,8'h1C,8'h61,3'd0,1,0));
        // Fill queue in REPEAT and overflow, ahead of the async reset
        vecs.push_back(mk(8'h1C,8'h61,3'd0,1,0,0,20, 1,8'h1C,8'h61,3'd0,1,1));

        // Reset with 1C held
        clrn = 1'b0; cur_key = 8'h1C; ascii_key = 8'h61;
        shift = 1'b0; ctrl = 1'b0; alt = 1'b0; rep_en = 1'b1;
        ev_if.ev_rd = 1'b0; ev_if.ovf_clr = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 32'(ev_if.ev_valid), 32'd0);
        chk("rst_ovf",   32'(ev_if.ovf),      32'd0);
        chk("rst_scan",  32'(ev_if.ev_scan),  32'd0);
        clrn = 1'b1;
        tick();
        chk("rst_press_valid", 32'(ev_if.ev_valid), 32'd1);
        chk("rst_press_scan",  32'(ev_if.ev_scan),  32'h1C);
        chk("rst_press_ascii", 32'(ev_if.ev_ascii), 32'h61);
        chk("rst_press_rep",   32'(ev_if.ev_rep),   32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            cur_key     = vecs[i].key;
            ascii_key   = vecs[i].asc;
            {ctrl, alt, shift} = vecs[i].mods;
            rep_en      = vecs[i].ren;
            ev_if.ev_rd = vecs[i].rd;
            ev_if.ovf_clr = vecs[i].clr;
            repeat (vecs[i].cyc) tick();
            chk($sformatf("v%0d_valid", i), 32'(ev_if.ev_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_ovf", i),   32'(ev_if.ovf),      32'(vecs[i].e_ovf));
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_scan", i),  32'(ev_if.ev_scan),  32'(vecs[i].e_scan));
                chk($sformatf("v%0d_ascii", i), 32'(ev_if.ev_ascii), 32'(vecs[i].e_asc));
                chk($sformatf("v%0d_mods", i),  32'(ev_if.ev_mods),  32'(vecs[i].e_mods));
                chk($sformatf("v%0d_rep", i),   32'(ev_if.ev_rep),   32'(vecs[i].e_rep));
            end
        end

        // Async reset mid-cycle while in REPEAT with a full queue and ovf set
        #2;
        clrn = 1'b0;
        #1;
        chk("async_rst_valid", 32'(ev_if.ev_valid), 32'd0);
        chk("async_rst_ovf",   32'(ev_if.ovf),      32'd0);
        cur_key = 8'h00;
        repeat (2) tick();
        clrn = 1'b1;
        repeat (3) tick();
        chk("post_rst_idle_valid", 32'(ev_if.ev_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_kbd_repeat_sched
`default_nettype wire
